// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter that merges ALU results and load returns onto the single
// reg_file write port. ALU results wait in a small in-order queue; loads take priority
// until the queue has lost STARVE_MAX consecutive cycles, at which point the queue head
// is forced out. Flush drops queued ALU results of one task.
//
// Ports:
//   clk, rst                            clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_ts/rd/val   ALU result handshake and payload
//   mem_valid/mem_ready/mem_ts/rd/val   load return handshake and payload
//   flush, flush_ts                     drop queued ALU results of task flush_ts
//   ws, w_ts, rd_sel, rd_val            registered reg_file write port
//   pending                             number of queued ALU results
module wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned CntW      = (DEPTH <= 4) ? 3 : $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic            alu_ts,
  input  logic [3:0]      alu_rd,
  input  logic [15:0]     alu_val,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_ts,
  input  logic [3:0]      mem_rd,
  input  logic [15:0]     mem_val,
  input  logic            flush,
  input  logic            flush_ts,
  output logic            ws,
  output logic            w_ts,
  output logic [3:0]      rd_sel,
  output logic [15:0]     rd_val,
  output logic [CntW-1:0] pending
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        ts;
    logic [3:0]  rd;
    logic [15:0] val;
  } ent_t;

  // Entry 0 is always the head; the queue is kept compacted so flush can drop
  // arbitrary entries while survivors keep their order.
  ent_t            fifo_q [DEPTH];
  ent_t            fifo_d [DEPTH];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            ws_q, ws_d;
  logic            w_ts_q, w_ts_d;
  logic [3:0]      rd_sel_q, rd_sel_d;
  logic [15:0]     rd_val_q, rd_val_d;

  logic            has_data, forced, alu_acc, mem_acc, pop, bypass, push, head_drop;
  logic [CntW-1:0] k;

  always_comb begin
    has_data  = (cnt_q != '0);
    forced    = has_data && (starve_q == StW'(STARVE_MAX));
    alu_ready = !rst && (cnt_q < CntW'(DEPTH)) && !flush;
    mem_ready = !rst && !forced;
    alu_acc   = alu_valid && alu_ready;
    mem_acc   = mem_valid && mem_ready;
    // forced implies mem_ready=0, so a non-empty queue pops whenever no load is taken.
    pop       = has_data && !mem_acc;
    bypass    = !has_data && !mem_acc && alu_acc;
    push      = alu_acc && !bypass;
    head_drop = pop && flush && (fifo_q[0].ts == flush_ts);

    ws_d     = 1'b0;
    w_ts_d   = w_ts_q;
    rd_sel_d = rd_sel_q;
    rd_val_d = rd_val_q;
    if (mem_acc) begin
      ws_d     = 1'b1;
      w_ts_d   = mem_ts;
      rd_sel_d = mem_rd;
      rd_val_d = mem_val;
    end else if (pop) begin
      if (!head_drop) begin
        ws_d     = 1'b1;
        w_ts_d   = fifo_q[0].ts;
        rd_sel_d = fifo_q[0].rd;
        rd_val_d = fifo_q[0].val;
      end
    end else if (bypass) begin
      ws_d     = 1'b1;
      w_ts_d   = alu_ts;
      rd_sel_d = alu_rd;
      rd_val_d = alu_val;
    end

    // Rebuild the queue: drop the popped head and flushed entries, then append.
    fifo_d = fifo_q;
    k      = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CntW'(i) < cnt_q) && !(pop && (i == 0)) &&
          !(flush && (fifo_q[i].ts == flush_ts))) begin
        fifo_d[k[IdxW-1:0]] = fifo_q[i];
        k = k + CntW'(1);
      end
    end
    if (push) begin
      fifo_d[k[IdxW-1:0]] = '{ts: alu_ts, rd: alu_rd, val: alu_val};
      k = k + CntW'(1);
    end
    cnt_d = k;

    if (pop || !has_data) begin
      starve_d = '0;
    end else if (mem_acc && (starve_q != StW'(STARVE_MAX))) begin
      starve_d = starve_q + StW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      starve_q <= '0;
      ws_q     <= 1'b0;
      w_ts_q   <= 1'b0;
      rd_sel_q <= '0;
      rd_val_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      ws_q     <= ws_d;
      w_ts_q   <= w_ts_d;
      rd_sel_q <= rd_sel_d;
      rd_val_q <= rd_val_d;
    end
  end

  // Payload storage needs no reset; cnt_q alone says which entries are live.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign ws      = ws_q;
  assign w_ts    = w_ts_q;
  assign rd_sel  = rd_sel_q;
  assign rd_val  = rd_val_q;
  assign pending = cnt_q;

endmodule
